// File: rtl/four_in_gates_pkg.sv
// rtl/four_in_gates_pkg.sv - shared states, constants and gate truth-table function for the four-input gate checker
package four_in_gates_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC = 16;

    localparam int LED_AND  = 0;
    localparam int LED_NAND = 1;
    localparam int LED_OR   = 2;
    localparam int LED_NOR  = 3;
    localparam int LED_XOR  = 4;
    localparam int LED_XNOR = 5;

    // Truth table of the gate block: one led per reduction gate over a[3:0].
    function automatic logic [5:0] gates_expected(input logic [3:0] a);
        logic [5:0] led;
        led           = '0;
        led[LED_AND]  = &a;
        led[LED_NAND] = ~&a;
        led[LED_OR]   = |a;
        led[LED_NOR]  = ~|a;
        led[LED_XOR]  = ^a;
        led[LED_XNOR] = ~^a;
        return led;
    endfunction

    // Lab vector order drives the vector index bit-reversed so a[3] toggles fastest.
    function automatic logic [3:0] bit_reverse4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/four_in_gates_ref.sv
// rtl/four_in_gates_ref.sv - combinational reference model of the four-input gate block
module four_in_gates_ref
    import four_in_gates_pkg::*;
(
    input  logic [3:0] a,
    output logic [5:0] led
);

    assign led = gates_expected(a);

endmodule

// File: rtl/four_in_gates_checker.sv
// rtl/four_in_gates_checker.sv - self-test sweep engine for the gate block; FIRST_FAIL_CAPTURE_EN adds first-failure capture
module four_in_gates_checker
    import four_in_gates_pkg::*;
#(
    parameter int SETTLE_CYCLES = 50,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] dut_a,
    input  logic [5:0] dut_led,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic [3:0] fail_vec,
    output logic [5:0] fail_led
`endif
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       v_q, v_d;
    logic [4:0]       err_q, err_d;
    logic [5:0]       exp_led;
    logic             mismatch;
    logic             accept;

    four_in_gates_ref u_ref (
        .a   (dut_a),
        .led (exp_led)
    );

    assign dut_a    = bit_reverse4(v_q);
    assign mismatch = (dut_led != exp_led);
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign busy     = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done     = (state_q == DONE);
    assign pass     = (state_q == DONE) && (err_q == 5'd0);
    assign err_cnt  = err_q;

    // State, settle counter, vector index and error count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            v_q     <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    // Sweep sequencing: settle, sample-and-compare, advance vector or finish.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    v_d     = '0;
                    err_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 5'd1;
                end
                if (v_q == 4'(NUM_VEC - 1)) begin
                    state_d = DONE;
                end else begin
                    v_d     = v_q + 4'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    logic [3:0] fail_vec_q;
    logic [5:0] fail_led_q;

    assign fail_vec = fail_vec_q;
    assign fail_led = fail_led_q;

    // Latch the first mismatching vector of a sweep; later mismatches leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec_q <= '0;
            fail_led_q <= '0;
        end else if (accept) begin
            fail_vec_q <= '0;
            fail_led_q <= '0;
        end else if ((state_q == SAMPLE) && mismatch && (err_q == 5'd0)) begin
            fail_vec_q <= dut_a;
            fail_led_q <= dut_led;
        end
    end
`endif

endmodule

// File: tb/tb_four_in_gates_checker.sv
// tb/tb_four_in_gates_checker.sv - directed self-checking bench for four_in_gates_checker
module tb_four_in_gates_checker;

    localparam int S = 50;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dut_a;
    logic [5:0] dut_led;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic [3:0] fail_vec;
    logic [5:0] fail_led;
`endif

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int edges;

    logic [3:0] seq [16] = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b0010, 4'b1010, 4'b0110, 4'b1110,
                             4'b0001, 4'b1001, 4'b0101, 4'b1101, 4'b0011, 4'b1011, 4'b0111, 4'b1111};

    four_in_gates_checker #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dut_a   (dut_a),
        .dut_led (dut_led),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
`ifdef FIRST_FAIL_CAPTURE_EN
        ,
        .fail_vec(fail_vec),
        .fail_led(fail_led)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate block stand-in written from the truth table; mode 1 sticks led[4] low, mode 2 ties all leds low.
    always_comb begin
        dut_led = {~^dut_a, ^dut_a, ~|dut_a, |dut_a, ~&dut_a, &dut_a};
        if (mode == 1) dut_led[4] = 1'b0;
        if (mode == 2) dut_led = 6'b000000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start so the next posedge accepts it, then count edges until done.
    task automatic run_sweep(input bit inject, input bit seq_chk, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        if (seq_chk) begin
            chk("busy_after_start", 32'(busy), 32'd1);
            chk("done_after_start", 32'(done), 32'd0);
            chk("pass_after_start", 32'(pass), 32'd0);
            chk("err_after_start", 32'(err_cnt), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
            chk("fail_vec_after_start", 32'(fail_vec), 32'd0);
            chk("fail_led_after_start", 32'(fail_led), 32'd0);
`endif
        end
        while (done !== 1'b1 && n < 2000) begin
            if (seq_chk && (n % (S + 1) == 0) && (n / (S + 1) < 16))
                chk($sformatf("dut_a_vec%0d", n / (S + 1)), 32'(dut_a), 32'(seq[n / (S + 1)]));
            start = inject && (n == 10 || n == 400);
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dut_a", 32'(dut_a), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("rst_fail_vec", 32'(fail_vec), 32'd0);
        chk("rst_fail_led", 32'(fail_led), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Good model: full sequence, exact completion time, pass.
        run_sweep(1'b0, 1'b1, edges);
        chk("good_edges", 32'(edges), 32'd816);
        chk("good_pass", 32'(pass), 32'd1);
        chk("good_err", 32'(err_cnt), 32'd0);
        chk("good_busy", 32'(busy), 32'd0);
        chk("good_last_a", 32'(dut_a), 32'hF);

        // led[4] stuck low: every odd-parity vector fails.
        mode = 1;
        run_sweep(1'b0, 1'b0, edges);
        chk("stuck_edges", 32'(edges), 32'd816);
        chk("stuck_err", 32'(err_cnt), 32'd8);
        chk("stuck_pass", 32'(pass), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("stuck_fail_vec", 32'(fail_vec), 32'b1000);
        chk("stuck_fail_led", 32'(fail_led), 32'b000110);
`endif

        // Restart from DONE after a failing run: everything cleared, then pass.
        mode = 0;
        run_sweep(1'b0, 1'b1, edges);
        chk("rerun_edges", 32'(edges), 32'd816);
        chk("rerun_pass", 32'(pass), 32'd1);
        chk("rerun_err", 32'(err_cnt), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("rerun_fail_vec", 32'(fail_vec), 32'd0);
        chk("rerun_fail_led", 32'(fail_led), 32'd0);
`endif

        // All leds low: all 16 vectors fail, counter reaches 16 without wrap.
        mode = 2;
        run_sweep(1'b0, 1'b0, edges);
        chk("zero_err", 32'(err_cnt), 32'd16);
        chk("zero_pass", 32'(pass), 32'd0);
        chk("zero_done", 32'(done), 32'd1);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("zero_fail_vec", 32'(fail_vec), 32'd0);
        chk("zero_fail_led", 32'(fail_led), 32'd0);
`endif

        // start pulses at cycles 10 and 400 of a running sweep are ignored.
        mode = 0;
        run_sweep(1'b1, 1'b0, edges);
        chk("inject_edges", 32'(edges), 32'd816);
        chk("inject_pass", 32'(pass), 32'd1);
        chk("inject_err", 32'(err_cnt), 32'd0);

        // Reset at cycle 300 of a failing sweep aborts it; a fresh sweep then passes.
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dut_a", 32'(dut_a), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("mid_rst_fail_vec", 32'(fail_vec), 32'd0);
        chk("mid_rst_fail_led", 32'(fail_led), 32'd0);
`endif
        rst_n = 1'b1;
        mode  = 0;
        run_sweep(1'b0, 1'b0, edges);
        chk("post_rst_edges", 32'(edges), 32'd816);
        chk("post_rst_pass", 32'(pass), 32'd1);
        chk("post_rst_err", 32'(err_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
